// File: rtl/min_arb_pkg.sv
// Shared types and helpers for the bit-serial minimum-time arbiter.
//   state_e    : arbiter FSM states (IDLE, SCAN, DONE)
//   clog2_min1 : ceil(log2(value)), never less than 1, for counter/index widths
package min_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width needed to hold 0..value-1; a one-value range still gets one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 32'sd2) ? 32'sd1 : $clog2(value);
  endfunction

endpackage

// File: rtl/min_arb_pick.sv
// Combinational first-set picker used to resolve ties among surviving candidates.
//   mask_i   [N_CH]          candidate set
//   ptr_i    [$clog2(N_CH)]  search start (ignored, treated as 0, when RR_EN=0)
//   onehot_o [N_CH]          one-hot of the first set bit at/after the start, wrapping
//   idx_o    [$clog2(N_CH)]  index of that bit (0 when mask_i is empty)
module min_arb_pick
  import min_arb_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int RR_EN = 0
) (
  input  logic [N_CH-1:0]         mask_i,
  input  logic [$clog2(N_CH)-1:0] ptr_i,
  output logic [N_CH-1:0]         onehot_o,
  output logic [$clog2(N_CH)-1:0] idx_o
);

  localparam int IW = $clog2(N_CH);

  logic [IW-1:0] ptr_s;

  // Fixed-priority mode always starts the search at channel 0.
  assign ptr_s = (RR_EN != 0) ? ptr_i : '0;

  // Walk the channels in rotated order; the first set candidate wins.
  always_comb begin
    logic          found;
    logic          hit;
    logic [IW:0]   sum;
    logic [IW-1:0] pos;
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      sum = {1'b0, ptr_s} + (IW + 1)'(k);
      // Wrap modulo N_CH; works for non-power-of-two channel counts.
      sum = (sum >= (IW + 1)'(N_CH)) ? (sum - (IW + 1)'(N_CH)) : sum;
      pos = sum[IW-1:0];
      hit = mask_i[pos] & ~found;
      onehot_o[pos] = onehot_o[pos] | hit;
      idx_o = idx_o | (hit ? pos : '0);
      found = found | hit;
    end
  end

endmodule

// File: rtl/min_time_arb.sv
// Handshaked minimum-time arbiter. Searches the requesting channels' time words
// MSB first, one bit per clock, keeping only channels that can still be minimal.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (ready only while idle)
//   req_flag  [N_CH]      channel i is requesting
//   time_win  [N_CH*T_W]  channel i time at [i*T_W +: T_W]
//   out_valid / out_ready result handshake (result held until accepted)
//   time_flag [N_CH]      one-hot winner, zero when none
//   min_idx, min_val      winner index and time
//   none                  accepted request set was empty
module min_time_arb
  import min_arb_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int T_W   = 8,
  parameter int RR_EN = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_CH-1:0]         req_flag,
  input  logic [N_CH*T_W-1:0]     time_win,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_CH-1:0]         time_flag,
  output logic [$clog2(N_CH)-1:0] min_idx,
  output logic [T_W-1:0]          min_val,
  output logic                    none
);

  localparam int IW = $clog2(N_CH);
  localparam int BW = clog2_min1(T_W);

  state_e                      state_q;
  logic [N_CH-1:0]             cand_q;
  logic [N_CH-1:0][T_W-1:0]    time_q;
  logic [BW-1:0]               bit_q;
  logic [T_W-1:0]              val_q;
  logic [IW-1:0]               rr_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [N_CH-1:0]             time_flag_q;
  logic [IW-1:0]               min_idx_q;
  logic [T_W-1:0]              min_val_q;
  logic                        none_q;

  logic [N_CH-1:0]             col_s;
  logic [N_CH-1:0]             zero_s;
  logic [N_CH-1:0]             cand_d;
  logic [T_W-1:0]              val_d;
  logic [N_CH-1:0]             pick_oh_s;
  logic [IW-1:0]               pick_idx_s;

  // Bit-serial elimination step: candidates with a 0 in the current bit
  // beat any with a 1; if nobody has a 0, every candidate survives.
  always_comb begin
    col_s = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      col_s[ch] = time_q[ch][bit_q];
    end
    zero_s = cand_q & ~col_s;
    cand_d = (|zero_s) ? zero_s : cand_q;
    val_d  = val_q;
    val_d[bit_q] = ~(|zero_s);
  end

  min_arb_pick #(
    .N_CH  (N_CH),
    .RR_EN (RR_EN)
  ) u_pick (
    .mask_i   (cand_d),
    .ptr_i    (rr_q),
    .onehot_o (pick_oh_s),
    .idx_o    (pick_idx_s)
  );

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      time_q      <= '0;
      bit_q       <= BW'(T_W - 1);
      val_q       <= '0;
      rr_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      time_flag_q <= '0;
      min_idx_q   <= '0;
      min_val_q   <= '0;
      none_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cand_q     <= req_flag;
            time_q     <= time_win;
            bit_q      <= BW'(T_W - 1);
            val_q      <= '0;
            in_ready_q <= 1'b0;
            if (|req_flag) begin
              state_q <= SCAN;
            end else begin
              // Empty request set: report straight away without scanning.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              none_q      <= 1'b1;
              time_flag_q <= '0;
              min_idx_q   <= '0;
              min_val_q   <= '0;
            end
          end
        end
        SCAN: begin
          cand_q <= cand_d;
          val_q  <= val_d;
          if (bit_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            none_q      <= 1'b0;
            time_flag_q <= pick_oh_s;
            min_idx_q   <= pick_idx_s;
            min_val_q   <= val_d;
          end else begin
            bit_q <= bit_q - BW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            // Rotate priority past the channel just granted.
            if ((RR_EN != 0) && !none_q) begin
              rr_q <= (min_idx_q == IW'(N_CH - 1)) ? '0 : (min_idx_q + IW'(1));
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign time_flag = time_flag_q;
  assign min_idx   = min_idx_q;
  assign min_val   = min_val_q;
  assign none      = none_q;

endmodule

// File: tb/tb_min_time_arb.sv
module tb_min_time_arb;

  localparam int TW = 8;

  typedef struct {
    logic [7:0] tf;
    logic [2:0] idx;
    logic [7:0] val;
    logic       none;
    int         acc;
    int         stall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n     = 2'b00;
  logic [1:0]       in_valid  = 2'b00;
  logic [1:0]       out_ready = 2'b00;
  logic [1:0][7:0]  req       = '0;
  logic [1:0][63:0] tw        = '0;
  wire  [1:0]       in_ready;
  wire  [1:0]       out_valid;
  wire  [1:0]       none_w;
  wire  [1:0][7:0]  tf;
  wire  [1:0][2:0]  idx;
  wire  [1:0][7:0]  val;

  // instance 0: fixed priority, instance 1: round-robin
  min_time_arb #(.N_CH(8), .T_W(8), .RR_EN(0)) u_fix (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .req_flag(req[0]), .time_win(tw[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .time_flag(tf[0]), .min_idx(idx[0]), .min_val(val[0]), .none(none_w[0]));

  min_time_arb #(.N_CH(8), .T_W(8), .RR_EN(1)) u_rr (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .req_flag(req[1]), .time_win(tw[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .time_flag(tf[1]), .min_idx(idx[1]), .min_val(val[1]), .none(none_w[1]));

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   rr_m [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act === req_v) passes++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req_v, $time);
  endtask

  // Reference: smallest time among requesters; tie goes to the first
  // requester with that time in priority order starting at the rr pointer.
  function automatic exp_t model(input int i, input logic [7:0] r, input logic [63:0] t);
    exp_t e;
    int best, start, c;
    e.tf = '0; e.idx = '0; e.val = '0; e.none = 1'b1; e.acc = 0; e.stall = 0;
    best = 256;
    for (int k = 0; k < 8; k++)
      if (r[k] && int'(t[k*8 +: 8]) < best) best = int'(t[k*8 +: 8]);
    if (best < 256) begin
      e.none = 1'b0;
      e.val  = best[7:0];
      start  = (i == 1) ? rr_m[1] : 0;
      for (int k = 7; k >= 0; k--) begin
        c = (start + k) % 8;
        if (r[c] && int'(t[c*8 +: 8]) == best) e.idx = c[2:0];
      end
      e.tf[e.idx] = 1'b1;
    end
    return e;
  endfunction

  task automatic send(input int i, input logic [7:0] r, input logic [63:0] t, input int stall);
    int   g;
    exp_t e;
    g = 0;
    @(negedge clk);
    while (!in_ready[i] && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready[i]) begin
      chk("accept_timeout", {63'd0, in_ready[i]}, 64'd1);
    end else begin
      e = model(i, r, t);
      e.acc = cyc + 1;
      e.stall = stall;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
      req[i] = r;
      tw[i] = t;
      in_valid[i] = 1'b1;
      @(negedge clk);
      in_valid[i] = 1'b0;
    end
  endtask

  // Monitor / scoreboard
  exp_t        cur [2];
  int          hold [2] = '{0, 0};
  bit          seen [2] = '{1'b0, 1'b0};
  bit          hs   [2] = '{1'b0, 1'b0};
  logic [19:0] snap [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        seen[i] = 1'b0; hs[i] = 1'b0; hold[i] = 0; out_ready[i] = 1'b0; rr_m[i] = 0;
        if (i == 0) q0.delete(); else q1.delete();
      end else if (hs[i]) begin
        chk("ready_after_hs", {63'd0, in_ready[i]}, 64'd1);
        chk("valid_drop", {63'd0, out_valid[i]}, 64'd0);
        hs[i] = 1'b0;
        out_ready[i] = 1'b0;
      end else if (out_valid[i]) begin
        chk("busy_in_done", {63'd0, in_ready[i]}, 64'd0);
        if (!seen[i]) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            chk("unexpected_out", 64'd1, 64'd0);
            cur[i].none = none_w[i]; cur[i].idx = idx[i]; cur[i].stall = 0;
          end else begin
            cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("latency", 64'(cyc + 1 - cur[i].acc), cur[i].none ? 64'd1 : 64'(TW + 1));
            chk("time_flag", {56'd0, tf[i]}, {56'd0, cur[i].tf});
            chk("min_idx", {61'd0, idx[i]}, {61'd0, cur[i].idx});
            chk("min_val", {56'd0, val[i]}, {56'd0, cur[i].val});
            chk("none", {63'd0, none_w[i]}, {63'd0, cur[i].none});
          end
          snap[i] = {tf[i], idx[i], val[i], none_w[i]};
          hold[i] = cur[i].stall;
          seen[i] = 1'b1;
        end else begin
          chk("held_stable", {44'd0, tf[i], idx[i], val[i], none_w[i]}, {44'd0, snap[i]});
        end
        if (hold[i] > 0) begin
          out_ready[i] = 1'b0;
          hold[i]--;
        end else begin
          out_ready[i] = 1'b1;
          seen[i] = 1'b0;
          hs[i] = 1'b1;
          if (i == 1 && !cur[i].none) rr_m[1] = (int'(cur[i].idx) + 1) % 8;
        end
      end else begin
        out_ready[i] = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t;
    logic [7:0]  r;
    int          g;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", {63'd0, out_valid[i]}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready[i]}, 64'd1);
      chk("rst_outputs", {44'd0, tf[i], idx[i], val[i], none_w[i]}, 64'd0);
    end
    rst_n = 2'b11;

    // Fixed priority directed cases
    send(0, 8'hBF, {8'd21, 8'd0, 8'd200, 8'd33, 8'd20, 8'd90, 8'd20, 8'd50}, 0);
    send(0, 8'h80, {8'hFF, 56'd0}, 1);
    send(0, 8'h00, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 0);
    send(0, 8'hBF, {8'd21, 8'd0, 8'd200, 8'd33, 8'd20, 8'd90, 8'd20, 8'd50}, 0);

    // Back-pressure with input noise while the result is held
    send(0, 8'h5A, {8'd9, 8'd100, 8'd3, 8'd77, 8'd3, 8'd40, 8'd60, 8'd1}, 5);
    g = 0;
    while (!out_valid[0] && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("bp_reached_done", {63'd0, out_valid[0]}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      in_valid[0] = (k % 2 == 0);
      req[0] = 8'($urandom);
      tw[0] = {32'($urandom), 32'($urandom)};
      @(negedge clk);
    end
    in_valid[0] = 1'b0;

    // Round-robin directed cases
    for (int k = 0; k < 3; k++) send(1, 8'hFF, {8{8'd7}}, 0);
    send(1, 8'h01, {8{8'd7}}, 0);
    send(1, 8'h03, {8{8'd7}}, 0);

    // Reset in the middle of a scan (bit 3)
    send(1, 8'hFF, {8{8'd7}}, 0);
    repeat (4) @(negedge clk);
    chk("mid_scan_busy", {63'd0, in_ready[1]}, 64'd0);
    rst_n[1] = 1'b0;
    #1;
    chk("rst_mid_valid", {63'd0, out_valid[1]}, 64'd0);
    chk("rst_mid_ready", {63'd0, in_ready[1]}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    send(1, 8'hFF, {8{8'd7}}, 0);
    send(1, 8'h06, {8{8'd7}}, 0);

    // Randomized traffic on both modes
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 2; i++) begin
        r = 8'($urandom);
        if (n % 7 == 0) r = 8'h00;
        else if (n % 3 == 1) r = 8'h01 << $urandom_range(0, 7);
        for (int k = 0; k < 8; k++)
          t[k*8 +: 8] = (n % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        send(i, r, t, int'($urandom_range(0, 2)));
      end
    end

    g = 0;
    while ((q0.size() + q1.size() != 0 || out_valid != 2'b00) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 64'(q0.size() + q1.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
